// File: rtl/reg_file_pkg.sv
// Shared register-file constants: architectural address map, SP reset value, address helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package reg_file_pkg;

  // Architectural register addresses
  localparam logic [3:0] REG_R0      = 4'd0;
  localparam logic [3:0] REG_R1      = 4'd1;
  localparam logic [3:0] REG_R2      = 4'd2;
  localparam logic [3:0] REG_R3      = 4'd3;
  localparam logic [3:0] REG_R4      = 4'd4;
  localparam logic [3:0] REG_R5      = 4'd5;
  localparam logic [3:0] REG_R6      = 4'd6;
  localparam logic [3:0] REG_R7      = 4'd7;
  localparam logic [3:0] REG_SP      = 4'd8;
  localparam logic [3:0] REG_IH      = 4'd9;
  localparam logic [3:0] REG_T       = 4'd10;
  localparam logic [3:0] REG_RA      = 4'd11;
  localparam logic [3:0] REG_INVALID = 4'd15;

  // 12 implemented registers; 12-14 are reserved holes, 15 means "no register"
  localparam int NUM_REGS = 12;

  // Stack pointer comes out of reset pointing at the top of the stack region
  localparam logic [15:0] SP_RESET_DEFAULT = 16'hBF00;

  // True when the address names a physically implemented register
  function automatic logic addr_is_reg(input logic [3:0] addr);
    return addr <= REG_RA;
  endfunction

endpackage

// File: rtl/reg_bypass_mux.sv
// ID read-port selector: zero for unimplemented addresses, else write-back bypass, else stored data.
// Latency: purely combinational.
// Backpressure: none; always produces a value.
module reg_bypass_mux
  import reg_file_pkg::*;
(
  input  logic [3:0]  raddr,
  input  logic [15:0] stored_data,
  input  logic        byp_vld,
  input  logic [3:0]  byp_addr,
  input  logic [15:0] byp_data,
  output logic [15:0] rdata
);

  // Reserved/invalid addresses win over everything so they always read as zero
  always_comb begin
    rdata = stored_data;
    if (!addr_is_reg(raddr)) begin
      rdata = 16'h0000;
    end else if (byp_vld && (byp_addr == raddr)) begin
      rdata = byp_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Twelve-entry 16-bit register file with two bypassed ID read ports, one debug port, write stats.
// Latency: reads combinational (write data forwarded same cycle); writes land on the rising edge.
// Backpressure: none; every write to 0-11 commits, writes to 12-15 are dropped.
module reg_file
  import reg_file_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        rfi_clk,
  input  logic        rfi_rst,
  input  logic        rfi_wr,
  input  logic [3:0]  rfi_waddr,
  input  logic [15:0] rfi_wdata,
  input  logic [3:0]  rfi_raddr_a,
  input  logic [3:0]  rfi_raddr_b,
  output logic [15:0] rfo_rdata_a,
  output logic [15:0] rfo_rdata_b,
  input  logic [3:0]  rfi_dbg_addr,
  output logic [15:0] rfo_dbg_data,
  output logic [15:0] rfo_wr_count,
  output logic [3:0]  rfo_last_waddr
);

  logic [NUM_REGS-1:0][15:0] regs;
  logic [15:0]               stored_a;
  logic [15:0]               stored_b;
  logic                      commit;

  // Reset gates the commit so neither storage nor the bypass sees a write while rst is high
  assign commit = !rfi_rst && rfi_wr && addr_is_reg(rfi_waddr);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [15:0] RST_VAL = (i == int'(REG_SP)) ? SP_RESET : 16'h0000;
    logic [15:0] q;

    // Each register loads only on a committed write addressed to it
    always_ff @(posedge rfi_clk or posedge rfi_rst) begin
      if (rfi_rst) begin
        q <= RST_VAL;
      end else if (commit && (rfi_waddr == 4'(i))) begin
        q <= rfi_wdata;
      end
    end

    assign regs[i] = q;
  end

  // Stored-value lookup for all three read addresses; unimplemented addresses fall through to zero
  always_comb begin
    stored_a     = 16'h0000;
    stored_b     = 16'h0000;
    rfo_dbg_data = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rfi_raddr_a == 4'(i))  stored_a     = regs[i];
      if (rfi_raddr_b == 4'(i))  stored_b     = regs[i];
      if (rfi_dbg_addr == 4'(i)) rfo_dbg_data = regs[i];
    end
  end

  reg_bypass_mux u_mux_a (
    .raddr       (rfi_raddr_a),
    .stored_data (stored_a),
    .byp_vld     (commit),
    .byp_addr    (rfi_waddr),
    .byp_data    (rfi_wdata),
    .rdata       (rfo_rdata_a)
  );

  reg_bypass_mux u_mux_b (
    .raddr       (rfi_raddr_b),
    .stored_data (stored_b),
    .byp_vld     (commit),
    .byp_addr    (rfi_waddr),
    .byp_data    (rfi_wdata),
    .rdata       (rfo_rdata_b)
  );

  // Write statistics: free-running wrap counter and last committed address
  always_ff @(posedge rfi_clk or posedge rfi_rst) begin
    if (rfi_rst) begin
      rfo_wr_count   <= 16'h0000;
      rfo_last_waddr <= REG_INVALID;
    end else if (commit) begin
      rfo_wr_count   <= rfo_wr_count + 16'h0001;
      rfo_last_waddr <= rfi_waddr;
    end
  end

  // An unknown write enable cannot be trusted to either commit or not
  assert property (@(posedge rfi_clk) disable iff (rfi_rst) !$isunknown(rfi_wr));

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file against an array-based reference model.
// Latency: checks combinational reads 1ns after inputs change, state after each rising edge.
// Backpressure: n/a.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] wr_count;
  logic [3:0]  last_waddr;

  always #5 clk = ~clk;

  reg_file #(.SP_RESET(16'hBF00)) dut (
    .rfi_clk        (clk),
    .rfi_rst        (rst),
    .rfi_wr         (wr),
    .rfi_waddr      (waddr),
    .rfi_wdata      (wdata),
    .rfi_raddr_a    (raddr_a),
    .rfi_raddr_b    (raddr_b),
    .rfo_rdata_a    (rdata_a),
    .rfo_rdata_b    (rdata_b),
    .rfi_dbg_addr   (dbg_addr),
    .rfo_dbg_data   (dbg_data),
    .rfo_wr_count   (wr_count),
    .rfo_last_waddr (last_waddr)
  );

  // Reference model: plain array of architectural registers plus statistics
  logic [15:0] m_reg [12];
  logic [15:0] m_count;
  logic [3:0]  m_last;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_reg[i] = (i == 8) ? 16'hBF00 : 16'h0000;
    m_count = 16'h0000;
    m_last  = 4'hF;
  endtask

  // Expected read: zero outside 0-11; same-cycle forwarding only on read ports, only when a write commits
  function automatic logic [15:0] m_read(input logic [3:0] a, input logic use_byp);
    if (a > 4'd11) return 16'h0000;
    if (use_byp && !rst && wr && (waddr == a)) return wdata;
    return m_reg[a];
  endfunction

  task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    wr = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b; dbg_addr = d;
  endtask

  task automatic check_outputs(input string tag);
    #1;
    chk({tag, "_rdata_a"}, rdata_a, m_read(raddr_a, 1'b1));
    chk({tag, "_rdata_b"}, rdata_b, m_read(raddr_b, 1'b1));
    chk({tag, "_dbg"}, dbg_data, m_read(dbg_addr, 1'b0));
    chk({tag, "_count"}, wr_count, m_count);
    chk({tag, "_last"}, {12'h000, last_waddr}, {12'h000, m_last});
  endtask

  // Advance one clock: model commits with the inputs held across the rising edge
  task automatic step();
    @(posedge clk);
    if (!rst && wr && (waddr < 4'd12)) begin
      m_reg[waddr] = wdata;
      m_count      = m_count + 16'h0001;
      m_last       = waddr;
    end
    @(negedge clk);
  endtask

  task automatic sweep_dbg(input string tag);
    wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk(tag, dbg_data, m_read(4'(i), 1'b0));
    end
    @(negedge clk);
  endtask

  logic [15:0] saved_count;
  logic [3:0]  saved_last;

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd8, 4'd8);
    model_reset();

    // Reset values are visible before any clock edge
    #1;
    chk("rst_async_r0", rdata_a, 16'h0000);
    chk("rst_async_sp", rdata_b, 16'hBF00);
    chk("rst_async_count", wr_count, 16'h0000);
    chk("rst_async_last", {12'h000, last_waddr}, 16'h000F);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("rst_dbg", dbg_data, (i == 8) ? 16'hBF00 : 16'h0000);
    end
    @(negedge clk);

    // Write R3, then assert reset mid-cycle
    drive(1'b1, 4'd3, 16'h1234, 4'd3, 4'd8, 4'd3);
    #1;
    chk("r3_bypass", rdata_a, 16'h1234);
    step();
    #1;
    chk("r3_stored", dbg_data, 16'h1234);
    #1;
    rst = 1'b1;
    drive(1'b1, 4'd4, 16'h5555, 4'd3, 4'd8, 4'd3);
    model_reset();
    #1;
    chk("midrst_r3", rdata_a, 16'h0000);
    chk("midrst_sp", rdata_b, 16'hBF00);
    chk("midrst_dbg", dbg_data, 16'h0000);
    chk("midrst_count", wr_count, 16'h0000);
    chk("midrst_last", {12'h000, last_waddr}, 16'h000F);
    step();
    dbg_addr = 4'd4;
    check_outputs("rst_hold");
    rst = 1'b0;
    check_outputs("rst_release");
    step();
    #1;
    chk("first_commit_r4", dbg_data, 16'h5555);

    // Same-cycle bypass on port a, debug port shows old value until the edge
    drive(1'b1, 4'd5, 16'hA5A5, 4'd5, 4'd5, 4'd5);
    #1;
    chk("r5_byp_a", rdata_a, 16'hA5A5);
    chk("r5_byp_b", rdata_b, 16'hA5A5);
    chk("r5_dbg_old", dbg_data, 16'h0000);
    step();
    #1;
    chk("r5_dbg_new", dbg_data, 16'hA5A5);

    // Write to REG_INVALID is discarded entirely
    saved_count = m_count;
    saved_last  = m_last;
    drive(1'b1, 4'd15, 16'hFFFF, 4'd15, 4'd5, 4'd15);
    check_outputs("inv_wr");
    step();
    check_outputs("inv_wr_after");
    chk("inv_count", wr_count, saved_count);
    chk("inv_last", {12'h000, last_waddr}, {12'h000, saved_last});
    sweep_dbg("inv_sweep");

    // Disabled write: no bypass, no change
    drive(1'b0, 4'd2, 16'h7777, 4'd2, 4'd2, 4'd2);
    #1;
    chk("nowr_byp", rdata_a, 16'h0000);
    step();
    #1;
    chk("nowr_r2", dbg_data, 16'h0000);
    chk("nowr_count", wr_count, saved_count);

    // RA written, then valid and reserved addresses read side by side
    drive(1'b1, 4'd11, 16'h0042, 4'd0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 16'h0000, 4'd13, 4'd11, 4'd11);
    #1;
    chk("ra_port_b", rdata_b, 16'h0042);
    chk("rsvd_port_a", rdata_a, 16'h0000);
    @(negedge clk);

    // Randomised traffic across the whole address space
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (($urandom_range(0, 3) == 0) && wr) raddr_a = waddr;
      if (($urandom_range(0, 3) == 0) && wr) raddr_b = waddr;
      check_outputs("rnd");
      step();
    end
    sweep_dbg("rnd_sweep");

    // Walk the counter up to the wrap point
    while (m_count != 16'hFFFE) begin
      drive(1'b1, 4'($urandom_range(0, 11)), 16'($urandom), 4'd0, 4'd0, 4'd0);
      step();
    end
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 4'd0);
    #1;
    chk("cnt_fffe", wr_count, 16'hFFFE);
    drive(1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd0, 4'd7);
    step();
    #1;
    chk("cnt_ffff", wr_count, 16'hFFFF);
    drive(1'b1, 4'd9, 16'hCAFE, 4'd9, 4'd7, 4'd9);
    step();
    check_outputs("cnt_wrap");
    chk("cnt_zero", wr_count, 16'h0000);
    chk("cnt_last", {12'h000, last_waddr}, 16'h0009);
    sweep_dbg("final_sweep");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have the parameter SP_RESET, default 16'hBF00, giving the reset value of SP.
REQ-002 SHALL have port rfi_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rfi_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port rfi_wr, input, 1 bit: write-back enable from the MEM/WB register (1 = write).
REQ-005 SHALL have port rfi_waddr, input, 4 bits: write-back register address from MEM/WB.
REQ-006 SHALL have port rfi_wdata, input, 16 bits: write-back result from MEM/WB.
REQ-007 SHALL have ports rfi_raddr_a and rfi_raddr_b, input, 4 bits each: ID-stage read addresses.
REQ-008 SHALL have ports rfo_rdata_a and rfo_rdata_b, output, 16 bits each: ID-stage read data.
REQ-009 SHALL have port rfi_dbg_addr, input, 4 bits: debug/monitor read address.
REQ-010 SHALL have port rfo_dbg_data, output, 16 bits: debug read data, with no bypass.
REQ-011 SHALL have port rfo_wr_count, output, 16 bits: count of committed register writes.
REQ-012 SHALL have port rfo_last_waddr, output, 4 bits: address of the most recent committed write.

Function
REQ-013 SHALL decode the address map as: 0-7 = R0-R7, 8 = SP, 9 = IH, 10 = T, 11 = RA, 12-14 reserved, 15 = REG_INVALID.
REQ-014 SHALL commit a write on a rising edge only when rfi_wr=1 and rfi_waddr is in the range 0-11.
REQ-015 SHALL discard a write to address 12-15 with no effect on any state, the counter included.
REQ-016 SHALL return 16'h0000 on every read port for reads of address 12-15.
REQ-017 SHALL make reads combinational (zero latency) from the stored register contents.
REQ-018 SHALL bypass write data to rfo_rdata_a/b when the write commits in the current cycle and its address equals the read address, so ID sees the value being written.
REQ-019 SHALL NOT apply the REQ-018 bypass to rfo_dbg_data, which shows stored contents only.
REQ-020 SHALL keep the bypass consistent when both read ports name the same address as the write: both ports return rfi_wdata.
REQ-021 SHALL increment rfo_wr_count by 1 on each committed write, wrapping from 16'hFFFF to 16'h0000.
REQ-022 SHALL load rfo_last_waddr with rfi_waddr on each committed write and hold it otherwise.
REQ-023 SHALL treat X or Z on rfi_wr as a simulation assertion failure; no write may commit in that case.

Reset
REQ-024 SHALL, while rfi_rst=1 and independent of rfi_clk, hold R0-R7, IH, T and RA at 16'h0000.
REQ-025 SHALL, while rfi_rst=1, hold SP at SP_RESET, rfo_wr_count at 0 and rfo_last_waddr at 4'hF (REG_INVALID).
REQ-026 SHALL ignore any write presented while rfi_rst=1; the first commit occurs on the first rising edge after deassertion.
REQ-027 SHALL leave the bypass path active during reset, but no write commits, so reads return the reset values.

Structure
REQ-028 SHALL take the register address constants (R0-R7, SP, IH, T, RA, REG_INVALID) from the shared defines file; no local redefinition is permitted.
REQ-029 SHALL put the SP reset default in the shared defines file as a named constant.
REQ-030 SHALL instantiate one sub-module, reg_bypass_mux, once per ID read port, selecting among stored data, bypass data and zero.
REQ-031 SHALL implement storage as 12 discrete 16-bit registers, with no memory inference.

Verification
REQ-032 SHALL cover: assert rfi_rst mid-cycle after R3 was written with 16'h1234 -> R3 reads 0 immediately, SP reads 16'hBF00, count is 0 and last_waddr is 4'hF.
REQ-033 SHALL cover: write R5=16'hA5A5 with raddr_a=5 in the same cycle -> rdata_a=16'hA5A5 before the edge; dbg_data for address 5 shows the old value until after the edge.
REQ-034 SHALL cover: rfi_wr=1, waddr=15, wdata=16'hFFFF -> no register changes, count unchanged, last_waddr unchanged.
REQ-035 SHALL cover: rfi_wr=0, waddr=2, wdata=16'h7777 -> R2 unchanged and no bypass.
REQ-036 SHALL cover: preload the count to 16'hFFFE via writes, then perform two writes -> count reads 16'hFFFF, then 16'h0000.
REQ-037 SHALL cover: write RA=16'h0042, then read address 11 on port b and address 13 on port a -> rdata_b=16'h0042, rdata_a=16'h0000.
